// File: rtl/fft_source_peak.sv
// Avalon-ST consumer for the FFT source port: checks SOP/EOP framing and
// reports the peak-magnitude bin of each good frame.
module fft_source_peak #(
  parameter int DW      = 14,
  parameter int NPTS    = 1024,
  parameter int IDXW    = 10,
  parameter int HALF    = 1,
  parameter int SKIP_DC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 source_valid,
  input  logic                 source_sop,
  input  logic                 source_eop,
  input  logic [1:0]           source_error,
  input  logic [DW-1:0]        source_real,
  input  logic [DW-1:0]        source_imag,
  output logic                 source_ready,
  output logic                 peak_valid,
  output logic [IDXW-1:0]      peak_bin,
  output logic [2*DW-1:0]      peak_mag,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [15:0]          frame_count
);

  // state   | meaning
  // IDLE    | waiting for SOP; non-SOP beats are dropped
  // COLLECT | accumulating bins 1..NPTS-1, tracking the running maximum
  // REPORT  | one cycle of backpressure while the peak is published
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPTS - 1);
  localparam logic [IDXW:0]   HALF_PTS = (IDXW + 1)'(NPTS / 2);

  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic [2*DW-1:0]       r_best_mag;
  logic [IDXW-1:0]       r_best_idx;
  logic                  r_ready;
  logic                  r_peak_valid;
  logic [IDXW-1:0]       r_peak_bin;
  logic [2*DW-1:0]       r_peak_mag;
  logic                  r_err_pulse;
  logic [1:0]            r_err_code;
  logic [15:0]           r_frame_count;

  state_t                w_state_nxt;
  logic [IDXW-1:0]       w_idx_nxt;
  logic [2*DW-1:0]       w_best_mag_nxt;
  logic [IDXW-1:0]       w_best_idx_nxt;
  logic                  w_err;
  logic [1:0]            w_err_code;
  logic                  w_good;
  logic                  w_eval;
  logic                  w_start;
  logic                  w_acc;
  logic [IDXW-1:0]       w_bin;
  logic                  w_cand;
  logic signed [2*DW-1:0] w_re_ext;
  logic signed [2*DW-1:0] w_im_ext;
  logic signed [2*DW-1:0] w_re2;
  logic signed [2*DW-1:0] w_im2;
  logic [2*DW-1:0]       w_mag;

  assign w_acc    = source_valid && r_ready;
  // Squares are sign-extended to the full width first so the product is exact.
  assign w_re_ext = {{DW{source_real[DW-1]}}, source_real};
  assign w_im_ext = {{DW{source_imag[DW-1]}}, source_imag};
  assign w_re2    = w_re_ext * w_re_ext;
  assign w_im2    = w_im_ext * w_im_ext;
  assign w_mag    = $unsigned(w_re2) + $unsigned(w_im2);

  assign w_bin  = w_start ? '0 : r_idx;
  assign w_cand = ((HALF == 0) || ({1'b0, w_bin} < HALF_PTS)) &&
                  ((SKIP_DC == 0) || (w_bin != '0));

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_best_mag_nxt = r_best_mag;
    w_best_idx_nxt = r_best_idx;
    w_err          = 1'b0;
    w_err_code     = 2'd0;
    w_good         = 1'b0;
    w_eval         = 1'b0;
    w_start        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && source_sop) begin
          if (source_eop && (NPTS != 1)) begin
            w_err      = 1'b1;
            w_err_code = 2'd2;
          end else if (source_eop) begin
            w_eval      = 1'b1;
            w_start     = 1'b1;
            w_good      = 1'b1;
            w_state_nxt = S_REPORT;
          end else begin
            w_eval      = 1'b1;
            w_start     = 1'b1;
            w_idx_nxt   = IDXW'(1);
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (w_acc) begin
          if (source_error != 2'd0) begin
            w_err       = 1'b1;
            w_err_code  = 2'd3;
            w_state_nxt = S_IDLE;
          end else if (source_sop) begin
            w_err      = 1'b1;
            w_err_code = 2'd1;
            w_eval     = 1'b1;
            w_start    = 1'b1;
            w_idx_nxt  = IDXW'(1);
          end else if (r_idx == LAST_IDX) begin
            if (source_eop) begin
              w_eval      = 1'b1;
              w_good      = 1'b1;
              w_state_nxt = S_REPORT;
            end else begin
              w_err       = 1'b1;
              w_err_code  = 2'd2;
              w_state_nxt = S_IDLE;
            end
          end else if (source_eop) begin
            w_err       = 1'b1;
            w_err_code  = 2'd2;
            w_state_nxt = S_IDLE;
          end else begin
            w_eval    = 1'b1;
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A new frame clears the running maximum before its first bin is scored.
    if (w_start) begin
      w_best_mag_nxt = '0;
      w_best_idx_nxt = '0;
    end
    if (w_eval && w_cand && (w_mag > w_best_mag_nxt)) begin
      w_best_mag_nxt = w_mag;
      w_best_idx_nxt = w_bin;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_best_mag    <= '0;
      r_best_idx    <= '0;
      r_ready       <= 1'b0;
      r_peak_valid  <= 1'b0;
      r_peak_bin    <= '0;
      r_peak_mag    <= '0;
      r_err_pulse   <= 1'b0;
      r_err_code    <= 2'd0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_best_mag   <= w_best_mag_nxt;
      r_best_idx   <= w_best_idx_nxt;
      r_ready      <= (w_state_nxt != S_REPORT);
      r_peak_valid <= w_good;
      r_err_pulse  <= w_err;
      if (w_good) begin
        r_peak_bin    <= w_best_idx_nxt;
        r_peak_mag    <= w_best_mag_nxt;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_err) r_err_code <= w_err_code;
    end
  end

  assign source_ready = r_ready;
  assign peak_valid   = r_peak_valid;
  assign peak_bin     = r_peak_bin;
  assign peak_mag     = r_peak_mag;
  assign err_pulse    = r_err_pulse;
  assign err_code     = r_err_code;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_fft_source_peak.sv
// Scoreboard bench for fft_source_peak: directed frames push expected
// peak/error events, a negedge monitor pops and compares them.
module tb_fft_source_peak;

  logic               clk;
  logic               reset_n;
  logic               source_valid;
  logic               source_sop;
  logic               source_eop;
  logic [1:0]         source_error;
  logic signed [13:0] source_real;
  logic signed [13:0] source_imag;
  logic               source_ready;
  logic               peak_valid;
  logic [9:0]         peak_bin;
  logic [27:0]        peak_mag;
  logic               err_pulse;
  logic [1:0]         err_code;
  logic [15:0]        frame_count;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [9:0]  bin;
    logic [27:0] mag;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic signed [13:0] f_re [1024];
  logic signed [13:0] f_im [1024];

  fft_source_peak #(.DW(14), .NPTS(1024), .IDXW(10), .HALF(1), .SKIP_DC(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
    .source_ready(source_ready), .peak_valid(peak_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .err_pulse(err_pulse), .err_code(err_code),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_run++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push_peak(input logic [9:0] bin, input logic [27:0] mag, input logic [15:0] fc);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.bin = bin; e.mag = mag; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.bin = '0; e.mag = '0; e.fc = '0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && (peak_valid || err_pulse)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {30'd0, peak_valid, err_pulse}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_err) begin
          chk("err_evt_pulse", {31'd0, err_pulse}, 32'd1);
          chk("err_evt_nopeak", {31'd0, peak_valid}, 32'd0);
          chk("err_evt_code", {30'd0, err_code}, {30'd0, e.code});
        end else begin
          chk("peak_evt_valid", {31'd0, peak_valid}, 32'd1);
          chk("peak_evt_bin", {22'd0, peak_bin}, {22'd0, e.bin});
          chk("peak_evt_mag", {4'd0, peak_mag}, {4'd0, e.mag});
          chk("peak_evt_fc", {16'd0, frame_count}, {16'd0, e.fc});
        end
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < 1024; i++) begin
      f_re[i] = '0;
      f_im[i] = '0;
    end
  endtask

  task automatic put_beat(input bit sop, input bit eop, input logic [1:0] er,
                          input logic signed [13:0] re, input logic signed [13:0] im);
    int guard = 0;
    while (!source_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!source_ready) chk("ready_timeout", {31'd0, source_ready}, 32'd1);
    source_valid = 1'b1; source_sop = sop; source_eop = eop;
    source_error = er; source_real = re; source_imag = im;
    @(posedge clk); #1;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'd0;
  endtask

  task automatic drive_frame(input int n, input int eop_at, input int err_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(posedge clk); #1;
      end
      put_beat(i == 0, i == eop_at, (i == err_at) ? 2'b01 : 2'b00, f_re[i], f_im[i]);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sb.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    source_error = 2'd0; source_real = '0; source_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, source_ready}, 32'd0);
    chk("rst_peak_valid", {31'd0, peak_valid}, 32'd0);
    chk("rst_peak_bin", {22'd0, peak_bin}, 32'd0);
    chk("rst_peak_mag", {4'd0, peak_mag}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, source_ready}, 32'd1);

    // single tone at bin 37
    clear_frame();
    f_re[37] = 14'sd1000;
    push_peak(10'd37, 28'd1000000, 16'd1);
    drive_frame(1024, 1023, -1, 0);
    chk("t1_latency", {31'd0, peak_valid}, 32'd1);
    chk("t1_report_ready", {31'd0, source_ready}, 32'd0);
    wait_drain();

    // full-scale tie: lower index wins, 2^27 fits
    clear_frame();
    f_re[5] = -14'sd8192; f_im[5] = -14'sd8192;
    f_re[9] = -14'sd8192; f_im[9] = -14'sd8192;
    push_peak(10'd5, 28'd134217728, 16'd2);
    drive_frame(1024, 1023, -1, 0);
    chk("t2_latency", {31'd0, peak_valid}, 32'd1);
    wait_drain();

    // upper half and DC are excluded
    clear_frame();
    f_re[700] = 14'sd4000;
    f_re[100] = 14'sd10;
    f_re[0]   = 14'sd8000;
    push_peak(10'd100, 28'd100, 16'd3);
    drive_frame(1024, 1023, -1, 0);
    wait_drain();

    // SOP re-asserted at idx 300, then a complete frame; bin 511 is the last searched
    clear_frame();
    push_err(2'd1);
    drive_frame(300, -1, -1, 0);
    f_im[511] = -14'sd5000;
    f_im[512] = 14'sd8000;
    push_peak(10'd511, 28'd25000000, 16'd4);
    drive_frame(1024, 1023, -1, 0);
    chk("t4_latency", {31'd0, peak_valid}, 32'd1);
    wait_drain();

    // early EOP at idx 511
    clear_frame();
    push_err(2'd2);
    drive_frame(512, 511, -1, 0);
    chk("t5_err_latency", {31'd0, err_pulse}, 32'd1);
    wait_drain();
    chk("t5_err_code_hold", {30'd0, err_code}, 32'd2);
    chk("t5_fc_unchanged", {16'd0, frame_count}, 32'd4);

    // frame with random valid gaps
    clear_frame();
    f_re[200] = -14'sd300; f_im[200] = 14'sd400;
    push_peak(10'd200, 28'd250000, 16'd5);
    drive_frame(1024, 1023, -1, 1);
    chk("t5b_latency", {31'd0, peak_valid}, 32'd1);
    wait_drain();

    // source_error at idx 12, then a stray non-SOP beat is dropped in IDLE
    clear_frame();
    push_err(2'd3);
    drive_frame(13, -1, 12, 0);
    chk("t6_err_latency", {31'd0, err_pulse}, 32'd1);
    put_beat(1'b0, 1'b1, 2'b00, 14'sd5000, 14'sd5000);
    wait_drain();
    chk("t6_idle_ready", {31'd0, source_ready}, 32'd1);
    chk("t6_fc", {16'd0, frame_count}, 32'd5);
    chk("t6_peak_hold", {22'd0, peak_bin}, 32'd200);

    // asynchronous reset in mid-frame
    clear_frame();
    f_re[100] = 14'sd2000;
    drive_frame(400, -1, -1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, source_ready}, 32'd0);
    chk("mid_rst_peak_bin", {22'd0, peak_bin}, 32'd0);
    chk("mid_rst_peak_mag", {4'd0, peak_mag}, 32'd0);
    chk("mid_rst_err_code", {30'd0, err_code}, 32'd0);
    chk("mid_rst_fc", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_peak_valid", {31'd0, peak_valid}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_quiet", {30'd0, peak_valid, err_pulse}, 32'd0);

    // all-zero frame: no candidate above 0 reports bin 0, mag 0
    clear_frame();
    push_peak(10'd0, 28'd0, 16'd1);
    drive_frame(1024, 1023, -1, 0);
    chk("t7_latency", {31'd0, peak_valid}, 32'd1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_source_peak.md
Name: fft_source_peak

Overview:
Consumer for the FFT core's Avalon-ST source port: the output side of the FFT whose sink is fed by our framing driver. It accepts one NPTS-point complex frame per SOP/EOP pair and checks the framing. For each frame it computes the squared magnitude of every bin and reports the peak bin and its magnitude once the frame completes. Its outputs feed the tone-detection and display logic downstream.

Parameters:
DW, 14, width of signed real/imag samples
NPTS, 1024, points per FFT frame
IDXW, 10, bin index width (log2 NPTS)
HALF, 1, when 1 only bins 0..NPTS/2-1 are searched (real input, mirrored spectrum)
SKIP_DC, 1, when 1 bin 0 is excluded from the search

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
source_valid  in  1  FFT output beat valid
source_sop  in  1  first beat of frame
source_eop  in  1  last beat of frame
source_error  in  2  FFT error code; nonzero means the beat is bad
source_real  in  DW  signed real part
source_imag  in  DW  signed imaginary part
source_ready  out  1  backpressure to the FFT core
peak_valid  out  1  one-cycle pulse; peak outputs are valid
peak_bin  out  IDXW  index of the maximum-magnitude bin
peak_mag  out  2*DW  unsigned re^2+im^2 of that bin
err_pulse  out  1  one-cycle pulse on a framing or data error
err_code  out  2  last error cause: 1 = unexpected SOP, 2 = EOP index mismatch or missing EOP, 3 = source_error nonzero
frame_count  out  16  count of good frames; wraps at 2^16

Behaviour:
- Reset (async, reset_n low): all outputs 0, including source_ready, peak_bin, peak_mag, err_code and frame_count. State is IDLE. source_ready rises on the first clk edge after reset_n deasserts.
- A beat is accepted only when source_valid && source_ready.
- Magnitude: mag = re*re + im*im, computed in signed arithmetic and zero-extended to 2*DW. The maximum 2^27 fits in 28 bits, so the sum never overflows.
- A bin is a search candidate when it satisfies all of: (HALF=0 or idx < NPTS/2) and (SKIP_DC=0 or idx != 0).
- The best magnitude starts at 0 with best index 0, and is updated only on strictly greater mag. On ties the lowest index wins.
- If no candidate has mag > 0, the report is bin 0 with magnitude 0.
- States:
  - IDLE: source_ready=1. Accepted beats without SOP are discarded silently. A beat with SOP is bin 0: evaluate it, set idx=1, go to COLLECT.
  - COLLECT: source_ready=1. Each accepted beat is bin idx; evaluate it, then idx++.
  - COLLECT, SOP on an accepted beat: err_code=1, err_pulse next cycle. The frame restarts with that beat as bin 0, and the best value is cleared before evaluating it.
  - COLLECT, EOP with idx==NPTS-1: this is a good frame; go to REPORT.
  - COLLECT, EOP with idx!=NPTS-1, or idx==NPTS-1 without EOP: err_code=2; go to IDLE.
  - COLLECT, source_error!=0 on an accepted beat: err_code=3; go to IDLE. This check has priority over SOP/EOP checks on the same beat.
  - REPORT: lasts one cycle with source_ready=0. peak_valid=1, peak_bin/peak_mag are registered from the best value, and frame_count increments. Then go to IDLE.
  - SOP and EOP on the same beat in IDLE: error with err_code=2 (one-point frame), unless NPTS==1.
- Latency: peak_valid is asserted exactly 1 cycle after the clock edge that accepts the final EOP beat.
- err_pulse is asserted 1 cycle after the offending beat.
- peak_bin and peak_mag hold their values until the next REPORT.
- err_code holds until the next error.
- An asynchronous reset in mid-frame discards the partial frame; no pulse is generated.

Test Plan:
- Reset, then a frame with bin 37 = (1000,0) and all other bins 0 -> peak_valid 1 cycle after EOP, peak_bin=37, peak_mag=1000000, frame_count=1.
- Bins 5 and 9 both = (-8192,-8192) -> peak_bin=5, peak_mag=134217728 (2^27, no overflow).
- HALF=1, bin 700 = (4000,0), bin 100 = (10,0) -> peak_bin=100; bin 0 = (8000,0) with SKIP_DC=1 -> bin 0 ignored.
- SOP re-asserted at idx 300 followed by a full 1024-beat frame -> err_pulse once with err_code=1, then a good report; frame_count increments by 1 only.
- EOP at idx 511 -> err_pulse, err_code=2, no peak_valid. Next frame: source_valid toggled randomly -> correct peak, no error.
- source_error=2'b01 at idx 12 -> err_code=3, state IDLE. reset_n pulsed low at idx 400 -> all outputs 0 and no peak_valid.
